// File: rtl/cla_nibble_serial_add_if.sv
// Operand and result channels of the nibble-serial adder.
//   i_valid/o_ready : operand handshake (source -> adder)
//   i_a, i_b, i_c   : operands and carry-in, sampled on acceptance
//   o_valid/i_ready : result handshake (adder -> consumer)
//   o_s, o_c        : sum and carry-out, held while o_valid is high
// Modport slave is the adder side; master is the source/consumer side.
interface cla_nibble_serial_add_if #(
  parameter int unsigned BW_DATA = 16
);
  logic               i_valid;
  logic               o_ready;
  logic [BW_DATA-1:0] i_a;
  logic [BW_DATA-1:0] i_b;
  logic               i_c;
  logic               o_valid;
  logic               i_ready;
  logic [BW_DATA-1:0] o_s;
  logic               o_c;

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_ready,
    output o_ready, o_valid, o_s, o_c
  );

  modport master (
    output i_valid, i_a, i_b, i_c, i_ready,
    input  o_ready, o_valid, o_s, o_c
  );
endinterface

// File: rtl/cla_nibble_serial_add.sv
// cla_4b: combinational 4-bit carry-lookahead adder slice.
//   i_a, i_b : 4-bit addends    i_c : carry-in
//   o_s      : 4-bit sum        o_c : carry-out
// cla_nibble_serial_add: BW_DATA-bit adder that feeds one nibble per cycle,
// LSB first, through a single cla_4b, with a registered carry between nibbles.
//   i_clk : clock, rising edge
//   i_rst : synchronous reset, active-high
//   bus   : operand/result channels (cla_nibble_serial_add_if.slave)
module cla_4b (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];
endmodule

module cla_nibble_serial_add #(
  parameter int unsigned BW_DATA = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  cla_nibble_serial_add_if.slave  bus
);
  localparam int unsigned NNIB = BW_DATA / 4;
  localparam int unsigned IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [BW_DATA-1:0] r_a;
  logic [BW_DATA-1:0] r_b;
  logic [BW_DATA-1:0] r_acc;
  logic               r_carry;
  logic [IDXW-1:0]    r_idx;
  logic [BW_DATA-1:0] r_s;
  logic               r_c;
  logic               r_valid;

  logic [IDXW+1:0]    w_bitpos;
  logic [3:0]         w_nib_a;
  logic [3:0]         w_nib_b;
  logic [3:0]         w_slice_s;
  logic               w_slice_c;
  logic [BW_DATA-1:0] w_acc_next;
  logic               w_last;

  assign w_bitpos = {r_idx, 2'b00};
  assign w_nib_a  = r_a[w_bitpos +: 4];
  assign w_nib_b  = r_b[w_bitpos +: 4];
  assign w_last   = (r_idx == IDXW'(NNIB - 1));

  cla_4b u_slice (
    .i_a (w_nib_a),
    .i_b (w_nib_b),
    .i_c (r_carry),
    .o_s (w_slice_s),
    .o_c (w_slice_c)
  );

  // Accumulator with the current nibble merged in, so the final nibble can be
  // forwarded straight to o_s in the same cycle it is computed.
  always_comb begin
    w_acc_next = (r_acc & ~({{(BW_DATA-4){1'b0}}, 4'hF} << w_bitpos))
               | ({{(BW_DATA-4){1'b0}}, w_slice_s} << w_bitpos);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_carry <= bus.i_c;
            r_idx   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice_c;
          if (w_last) begin
            r_s     <= w_acc_next;
            r_c     <= w_slice_c;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready = (r_state == S_IDLE) && !i_rst;
  assign bus.o_valid = r_valid;
  assign bus.o_s     = r_s;
  assign bus.o_c     = r_c;
endmodule

// File: tb/tb_cla_nibble_serial_add.sv
module tb_cla_nibble_serial_add;
  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cla_nibble_serial_add_if #(.BW_DATA(W)) bus ();

  cla_nibble_serial_add #(.BW_DATA(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    ref_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // present operands while o_ready is high and step through the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    bus.i_a = a; bus.i_b = b; bus.i_c = c; bus.i_valid = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!bus.o_ready) begin
      errors++;
      $display("FAIL issue_ready: o_ready=%0b required 1", bus.o_ready);
    end
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.o_valid && n < 40) begin tick(); n++; end
    checks++;
    if (!bus.o_valid) begin
      errors++;
      $display("FAIL wait_valid: o_valid=%0b required 1 (timeout)", bus.o_valid);
    end
  endtask

  task automatic check_result(input string name, input logic [W:0] exp);
    checks++;
    if ({bus.o_c, bus.o_s} !== exp) begin
      errors++;
      $display("FAIL %s: got c=%0b s=%h required c=%0b s=%h", name, bus.o_c, bus.o_s,
               exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_s !== 16'h0000 || bus.o_c !== 1'b0 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b s=%h c=%0b ready=%0b required 0 0000 0 0",
               bus.o_valid, bus.o_s, bus.o_c, bus.o_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: o_ready=%0b required 1", bus.o_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    bus.i_ready = 1'b0;
    issue(16'h1234, 16'h4321, 1'b0);
    wait_valid(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles required 4", n);
    end
    check_result("basic_sum", ref_sum(16'h1234, 16'h4321, 1'b0));
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_exclusive: o_ready=%0b required 0 while o_valid", bus.o_ready);
    end
    bus.i_ready = 1'b1;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop: o_valid=%0b required 0", bus.o_valid);
    end
  endtask

  task automatic test_ripple();
    int n;
    bus.i_ready = 1'b0;
    issue(16'hFFFF, 16'h0000, 1'b1);
    wait_valid(n);
    check_result("ripple_sum", 17'h1_0000);
    bus.i_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    bus.i_ready = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = i[0];
      bus.i_a = 16'h1111; bus.i_b = 16'h2222; bus.i_c = 1'b1;
      check_result("bp_hold", 17'h1_0000);
      checks++;
      if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_handshake: ready=%0b valid=%0b required 0 1", bus.o_ready, bus.o_valid);
      end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: o_valid=%0b required 0", bus.o_valid);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int n;
    bus.i_ready = 1'b1;
    issue(16'hABCD, 16'h1111, 1'b0);
    tick();            // first CALC edge done; now inside the 2nd CALC cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_valid: o_valid seen %0d cycles required 0", seen);
    end
    bus.i_ready = 1'b0;
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_valid(n);
    check_result("abort_next", 17'h0_0100);
    bus.i_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [W:0] expq[$];
    int accepted;
    int received;
    int cycles;
    logic [W:0] e;
    bus.i_a = W'($urandom); bus.i_b = W'($urandom); bus.i_c = 1'($urandom);
    bus.i_valid = 1'b1;
    accepted = 0; received = 0; cycles = 0;
    while ((accepted < 1000 || expq.size() != 0) && cycles < 30000) begin
      bus.i_valid = (accepted < 1000);
      bus.i_ready = 1'($urandom);
      #1;
      if (bus.o_ready && bus.o_valid) begin
        checks++;
        errors++;
        $display("FAIL rand_exclusive: ready=1 valid=1 at cycle %0d", cycles);
      end
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: result s=%h with nothing outstanding", bus.o_s);
        end else begin
          e = expq.pop_front();
          received++;
          if ({bus.o_c, bus.o_s} !== e) begin
            errors++;
            $display("FAIL rand_sum #%0d: got c=%0b s=%h required c=%0b s=%h", received,
                     bus.o_c, bus.o_s, e[W], e[W-1:0]);
          end
        end
      end
      if (bus.o_ready && bus.i_valid) begin
        expq.push_back(ref_sum(bus.i_a, bus.i_b, bus.i_c));
        accepted++;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (expq.size() != 0 && accepted > 0 && bus.o_ready) begin
        // previous transfer completed; present fresh operands
      end
      if (bus.o_ready) begin
        bus.i_a = W'($urandom); bus.i_b = W'($urandom); bus.i_c = 1'($urandom);
      end
    end
    bus.i_valid = 1'b0;
    checks++;
    if (received != 1000 || expq.size() != 0) begin
      errors++;
      $display("FAIL rand_count: received %0d outstanding %0d required 1000 0",
               received, expq.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_c = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
